// File: rtl/vlc_pkg.sv
// Shared types and helpers for the VLC bit packer: word width default,
// packer FSM states, accumulator fill width and the codeword mask builder.
package vlc_pkg;

    localparam int VLC_WORD_W = 32;
    // fill counts 0..2*WORD_W pending bits
    localparam int VLC_FILL_W = $clog2(2 * VLC_WORD_W + 1);
    // widest field the mask helper can describe
    localparam int VLC_MASK_W = 64;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } vlc_state_t;

    // Mask with the top 'len' bits of a 'width'-bit field set (bit width-1 is the MSB).
    function automatic logic [VLC_MASK_W-1:0] vlc_left_mask(input int unsigned len,
                                                            input int unsigned width);
        logic [VLC_MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < VLC_MASK_W; i++) begin
            if ((i < width) && (i + len >= width)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/vlc_word_slot.sv
// One-entry output register for packed words.
// valid/ready: a word moves when out_valid && out_ready on a rising edge;
// out_valid/out_data hold steady until then, and a new load may land in the
// same cycle the previous word leaves.
module vlc_word_slot #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              free
);

    // free when empty, or when the current word is being taken this cycle
    always_comb begin
        free = !out_valid || out_ready;
    end

    // capture a new word, or empty the slot once the consumer takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vlc_bit_packer.sv
// Packs variable-length codewords MSB-first into WORD_W-bit bitstream words.
// Optional feature macro: VLC_PACKER_BITCNT_EN (builds the total_bits counter;
// otherwise total_bits is tied to zero).
// Handshakes: a codeword is taken when in_valid && in_ready; a word leaves
// when out_valid && out_ready. in_ready depends on registered state only.
module vlc_bit_packer
    import vlc_pkg::*;
#(
    parameter int WORD_W = VLC_WORD_W,
    parameter int LEN_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_sum,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              err,
    output logic [31:0]       total_bits
);

    localparam int FILL_W = $clog2(2 * WORD_W + 1);
    localparam int ACC_W  = 2 * WORD_W;
    localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(WORD_W);
    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(WORD_W);

    vlc_state_t        state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  base_acc;
    logic [ACC_W-1:0]  acc_next;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] base_fill;
    logic [FILL_W-1:0] fill_next;
    logic [FILL_W-1:0] len_f;
    logic [WORD_W-1:0] field;
    logic              err_q;
    logic              flush_done_q;
    logic              slot_free;
    logic              accept;
    logic              len_ok;
    logic              take;
    logic              full_xfer;
    logic              pad_xfer;
    logic              xfer;

    // accept/transfer decisions and the next accumulator contents
    always_comb begin
        in_ready  = (state_q == RUN) && (fill_q <= WORD_FILL);
        accept    = in_valid && in_ready;
        len_ok    = (in_len <= MAX_LEN);
        take      = accept && len_ok && (in_len != '0);
        len_f     = len_ok ? FILL_W'(in_len) : '0;
        full_xfer = (fill_q >= WORD_FILL) && slot_free;
        // in FLUSH a short remainder leaves as one zero-padded word
        pad_xfer  = (state_q == FLUSH) && (fill_q != '0) && (fill_q < WORD_FILL) && slot_free;
        xfer      = full_xfer || pad_xfer;
        base_acc  = xfer ? (acc_q << WORD_W) : acc_q;
        if (full_xfer) begin
            base_fill = fill_q - WORD_FILL;
        end else if (pad_xfer) begin
            base_fill = '0;
        end else begin
            base_fill = fill_q;
        end
        // codeword left-aligned in a word, keeping only its len bits
        field = (in_sum << (WORD_FILL - len_f))
                & WORD_W'(vlc_left_mask(32'(len_f), WORD_W));
        acc_next  = base_acc;
        fill_next = base_fill;
        if (take) begin
            acc_next  = base_acc | ({field, {WORD_W{1'b0}}} >> base_fill);
            fill_next = base_fill + len_f;
        end
    end

    // flush FSM with accumulator, error flag and done pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            err_q        <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            acc_q        <= acc_next;
            fill_q       <= fill_next;
            flush_done_q <= 1'b0;
            if (accept && !len_ok) begin
                err_q <= 1'b1;
            end
            case (state_q)
                RUN: begin
                    if (flush_req) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if ((fill_q == '0) && slot_free) begin
                        state_q      <= DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    vlc_word_slot #(
        .WORD_W(WORD_W)
    ) u_slot (
        .clk      (clk),
        .reset    (reset),
        .load     (xfer),
        .load_data(acc_q[ACC_W-1 -: WORD_W]),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .free     (slot_free)
    );

    assign err        = err_q;
    assign flush_done = flush_done_q;

`ifdef VLC_PACKER_BITCNT_EN
    logic [31:0] total_bits_q;

    // running count of legal codeword bits, cleared when a flush completes
    always_ff @(posedge clk) begin
        if (reset) begin
            total_bits_q <= '0;
        end else if (state_q == DONE) begin
            total_bits_q <= '0;
        end else if (take) begin
            total_bits_q <= total_bits_q + 32'(len_f);
        end
    end

    assign total_bits = total_bits_q;
`else
    assign total_bits = '0;
`endif

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed bench for vlc_bit_packer: reset, packing, flush, backpressure,
// illegal lengths and reset during flush, with a queue-based word scoreboard.
module tb_vlc_bit_packer;

    localparam int W = 32;

`ifdef VLC_PACKER_BITCNT_EN
    localparam logic [31:0] CNT_3 = 32'd3;
`else
    localparam logic [31:0] CNT_3 = 32'd0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_sum;
    logic [31:0]  in_len;
    logic         flush_req;
    logic         flush_done;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         err;
    logic [31:0]  total_bits;

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    vlc_bit_packer #(
        .WORD_W(W),
        .LEN_W (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_len    (in_len),
        .flush_req (flush_req),
        .flush_done(flush_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .total_bits(total_bits)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // scoreboard: every word leaving the DUT must match the head of exp_q
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_word", {31'b0, out_valid}, 32'd0);
            end else begin
                check("sb_word", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // drive one codeword and hold it until the DUT takes it
    task automatic send(input logic [31:0] sum, input logic [31:0] len);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_sum   = sum;
        in_len   = len;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 100) begin
            tick(1);
            i++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int pulses;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_len    = '0;
        flush_req = 1'b0;
        out_ready = 1'b1;

        // 1: reset held two cycles
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready",   {31'b0, in_ready},   32'd1);
        check("rst_out_valid",  {31'b0, out_valid},  32'd0);
        check("rst_err",        {31'b0, err},        32'd0);
        check("rst_flush_done", {31'b0, flush_done}, 32'd0);
        check("rst_total_bits", total_bits,          32'd0);
        tick(1);

        // 2: four bytes form one word, visible two cycles after the last accept
        exp_q.push_back(32'hAABBCCDD);
        send(32'hAA, 8);
        send(32'hBB, 8);
        send(32'hCC, 8);
        send(32'hDD, 8);
        @(negedge clk);
        check("t2_lat_n1_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t2_lat_n2_valid", {31'b0, out_valid}, 32'd1);
        check("t2_lat_n2_data",  out_data,           32'hAABBCCDD);
        tick(5);
        wait_drain("t2_drain");

        // 3: three bits then flush -> padded word and a single done pulse
        exp_q.push_back(32'hA0000000);
        send(32'h5, 3);
        @(negedge clk);
        check("t3_cnt_pre", total_bits, CNT_3);
        @(posedge clk);
        #1;
        pulse_flush();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (flush_done) begin
                pulses++;
                if (pulses == 1) check("t3_cnt_in_done", total_bits, CNT_3);
            end
        end
        check("t3_done_pulses", 32'(pulses), 32'd1);
        check("t3_in_ready",    {31'b0, in_ready}, 32'd1);
        check("t3_cnt_post",    total_bits, 32'd0);
        wait_drain("t3_drain");
        tick(1);

        // 4: backpressure with three full words
        out_ready = 1'b0;
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'h22222222);
        exp_q.push_back(32'h33333333);
        send(32'h11111111, 32);
        send(32'h22222222, 32);
        send(32'h33333333, 32);
        @(negedge clk);
        check("t4_in_ready_full", {31'b0, in_ready},  32'd0);
        check("t4_hold_valid",    {31'b0, out_valid}, 32'd1);
        check("t4_hold_data",     out_data,           32'h11111111);
        tick(3);
        @(negedge clk);
        check("t4_hold_data_late", out_data, 32'h11111111);
        tick(1);
        out_ready = 1'b1;
        wait_drain("t4_drain");

        // 5: zero and oversize lengths are discarded, oversize sets sticky err
        check("t5_err_pre", {31'b0, err}, 32'd0);
        exp_q.push_back(32'hFFFFFFFF);
        send(32'hF, 4);
        send(32'h0, 0);
        send(32'h1FF, 33);
        send(32'h0FFFFFFF, 28);
        wait_drain("t5_drain");
        check("t5_err_set", {31'b0, err}, 32'd1);
        tick(3);
        check("t5_err_sticky", {31'b0, err}, 32'd1);

        // 6: reset while flushing with a word held in the slot
        out_ready = 1'b0;
        send(32'hDEADBEEF, 32);
        send(32'h9, 4);
        pulse_flush();
        tick(4);
        @(negedge clk);
        check("t6_pre_valid",    {31'b0, out_valid},  32'd1);
        check("t6_pre_in_ready", {31'b0, in_ready},   32'd0);
        check("t6_pre_done",     {31'b0, flush_done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_valid",    {31'b0, out_valid},  32'd0);
        check("t6_rst_in_ready", {31'b0, in_ready},   32'd1);
        check("t6_rst_done",     {31'b0, flush_done}, 32'd0);
        check("t6_rst_err",      {31'b0, err},        32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (flush_done) pulses++;
        end
        check("t6_no_done", 32'(pulses), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back(32'h12345678);
        send(32'h12345678, 32);
        wait_drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
